// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU/timing side and the OAM DMA controller.
// master drives the M-cycle tick and the FF46 write port; slave is the controller.
interface oam_dma_ctrl_if;
  logic        mcyc_en;
  logic        reg_wr;
  logic [7:0]  reg_d;
  logic [7:0]  reg_q;
  logic [15:0] dma_a;
  logic        dma_run;
  logic        oam_addr_ndma;
  logic        vram_to_oam;
  logic        dma_oam_wr;
  logic        dma_done;

  modport master (
    output mcyc_en, reg_wr, reg_d,
    input  reg_q, dma_a, dma_run, oam_addr_ndma, vram_to_oam, dma_oam_wr, dma_done
  );

  modport slave (
    input  mcyc_en, reg_wr, reg_d,
    output reg_q, dma_a, dma_run, oam_addr_ndma, vram_to_oam, dma_oam_wr, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// FF46 OAM DMA sequencer: copies 160 bytes from {src, 0x00..0x9F} into OAM,
// one byte per M-cycle, with restart on rewrite and echo-RAM source mapping.
module oam_dma_ctrl (
  input  logic          clk,
  input  logic          nreset,
  oam_dma_ctrl_if.slave bus
);
  localparam logic [7:0] LAST_IDX = 8'd159;

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t     state;
  logic       pend;
  logic       rst_f;
  logic       done_q;
  logic [7:0] new_src;
  logic [7:0] act_src;
  logic [7:0] idx;
  logic [7:0] reg_q;
  logic       dma_run;

  // Sources in 0xE0..0xFF alias work RAM at 0xC0..0xDF.
  function automatic logic [7:0] map_src(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

  // NOTE: every state register uses <= so all branches see pre-edge values;
  // that is what keeps a write on a tick clock from being consumed by that tick.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state   <= IDLE;
      pend    <= 1'b0;
      rst_f   <= 1'b0;
      done_q  <= 1'b0;
      new_src <= 8'h00;
      act_src <= 8'h00;
      idx     <= 8'h00;
      reg_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (bus.mcyc_en) begin
        unique case (state)
          IDLE: begin
            if (pend) begin
              state   <= START;
              act_src <= map_src(new_src);
              pend    <= 1'b0;
              idx     <= 8'h00;
              rst_f   <= 1'b0;
            end
          end
          START: begin
            if (pend) begin
              act_src <= map_src(new_src);
              pend    <= 1'b0;
            end else begin
              state <= RUN;
              idx   <= 8'h00;
            end
          end
          RUN: begin
            if (pend) begin
              state   <= START;
              act_src <= map_src(new_src);
              pend    <= 1'b0;
              idx     <= 8'h00;
              rst_f   <= 1'b1;
            end else if (idx == LAST_IDX) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
      // NOTE: placed after the sequencer so a fresh write re-arms pend even on
      // the tick that clears the previous request.
      if (bus.reg_wr) begin
        new_src <= bus.reg_d;
        reg_q   <= bus.reg_d;
        pend    <= 1'b1;
      end
    end
  end

  // A restart keeps the bus through START; a fresh transfer leaves OAM free there.
  assign dma_run           = (state == RUN) || ((state == START) && rst_f);
  assign bus.dma_run       = dma_run;
  assign bus.oam_addr_ndma = !dma_run;
  assign bus.vram_to_oam   = dma_run && (act_src[7:5] == 3'b100);
  assign bus.dma_oam_wr    = (state == RUN) && bus.mcyc_en && nreset;
  assign bus.dma_a         = {act_src, idx};
  assign bus.dma_done      = done_q;
  assign bus.reg_q         = reg_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: each FF46 write queues its expected OAM
// writes (address and tick number); a negedge monitor pops and compares them.
module tb_oam_dma_ctrl;
  logic clk;
  logic nreset;

  oam_dma_ctrl_if bus();

  oam_dma_ctrl dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          tick;
    bit          last;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         ticks    = 0;
  int         cur_p    = 0;
  bit         have_cur = 0;
  int         exp_done = 0;
  int         done_seen = 0;
  logic [7:0] exp_regq = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, got, exp, ticks);
    end
  endtask

  function automatic logic [7:0] map_src(input logic [7:0] v);
    return (v >= 8'hE0) ? v - 8'h20 : v;
  endfunction

  // A write seen at tick count p is consumed on tick p+1 and byte i moves on
  // tick p+3+i. A later write at q lets the old transfer complete q-p-1 bytes
  // (capped at 160); dma_done only if the old transfer ended before tick q+1.
  task automatic note_write(input logic [7:0] d);
    int c;
    if (have_cur) begin
      c = ticks - cur_p - 1;
      if (c >= 161) exp_done++;
      if (c < 0) c = 0;
      for (int k = c; k < 160; k++) void'(sb.pop_back());
    end
    for (int i = 0; i < 160; i++) begin
      exp_t e;
      e.addr = {map_src(d), 8'(i)};
      e.tick = ticks + 3 + i;
      e.last = (i == 159);
      sb.push_back(e);
    end
    cur_p    = ticks;
    have_cur = 1'b1;
    exp_regq = d;
  endtask

  task automatic cyc(input bit en, input bit wr = 1'b0, input logic [7:0] d = 8'h00);
    @(posedge clk);
    #1;
    bus.mcyc_en = en;
    bus.reg_wr  = wr;
    bus.reg_d   = d;
    if (en) ticks++;
    if (wr) note_write(d);
  endtask

  task automatic tick_to(input int t, input int per);
    while (ticks < t) begin
      repeat (per - 1) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  // Monitor: compares every OAM write pulse and every done pulse.
  initial begin
    exp_t e;
    bit   prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (nreset !== 1'b1) begin
        prev_last = 1'b0;
        continue;
      end
      if (bus.dma_done === 1'b1) begin
        done_seen++;
        check("done_follows_last_byte", 32'(prev_last), 32'd1);
      end
      prev_last = 1'b0;
      if (bus.dma_oam_wr === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_oam_wr: got dma_a %0h expected no write (tick %0d)", bus.dma_a, ticks);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(bus.dma_a), 32'(e.addr));
          check("wr_tick", 32'(ticks), 32'(e.tick));
          check("wr_run", 32'(bus.dma_run), 32'd1);
          check("wr_ndma", 32'(bus.oam_addr_ndma), 32'd0);
          check("wr_vram", 32'(bus.vram_to_oam), 32'(e.addr[15:13] == 3'b100));
          prev_last = e.last;
        end
      end
    end
  end

  initial begin
    int p;
    int per;
    int gap;
    logic [7:0] d;

    bus.mcyc_en = 1'b0;
    bus.reg_wr  = 1'b0;
    bus.reg_d   = 8'h00;
    nreset      = 1'b0;

    // Reset, with a write and a tick presented on the last reset edge.
    repeat (2) @(posedge clk);
    #1;
    bus.reg_wr  = 1'b1;
    bus.reg_d   = 8'hAA;
    bus.mcyc_en = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wr  = 1'b0;
    bus.mcyc_en = 1'b0;
    nreset      = 1'b1;
    @(negedge clk);
    check("rst_reg_q", 32'(bus.reg_q), 32'h00);
    check("rst_dma_a", 32'(bus.dma_a), 32'h0000);
    check("rst_dma_run", 32'(bus.dma_run), 32'd0);
    check("rst_ndma", 32'(bus.oam_addr_ndma), 32'd1);
    check("rst_vram", 32'(bus.vram_to_oam), 32'd0);
    check("rst_oam_wr", 32'(bus.dma_oam_wr), 32'd0);
    check("rst_done", 32'(bus.dma_done), 32'd0);

    // Plain transfer from 0xC1, one tick every 4 clocks.
    cyc(1'b0, 1'b1, 8'hC1);
    p = ticks;
    tick_to(p + 1, 4);
    cyc(1'b0);
    @(negedge clk);
    check("fresh_start_no_run", 32'(bus.dma_run), 32'd0);
    tick_to(p + 162, 4);
    cyc(1'b0);
    @(negedge clk);
    check("c1_run_after_done", 32'(bus.dma_run), 32'd0);
    check("c1_reg_q", 32'(bus.reg_q), 32'hC1);

    // VRAM source, then echo-mapped source.
    cyc(1'b0, 1'b1, 8'h85);
    p = ticks;
    tick_to(p + 163, 4);
    cyc(1'b0);
    @(negedge clk);
    check("vram_after_done", 32'(bus.vram_to_oam), 32'd0);
    cyc(1'b0, 1'b1, 8'hFE);
    p = ticks;
    cyc(1'b0);
    @(negedge clk);
    check("echo_reg_q", 32'(bus.reg_q), 32'hFE);
    tick_to(p + 163, 4);

    // Rewrite during RUN at idx 0x40.
    cyc(1'b0, 1'b1, 8'hC0);
    p = ticks;
    tick_to(p + 8'h42, 4);
    cyc(1'b0, 1'b1, 8'hD0);
    tick_to(ticks + 1, 4);
    cyc(1'b0);
    @(negedge clk);
    check("restart_start_run", 32'(bus.dma_run), 32'd1);
    check("restart_start_ndma", 32'(bus.oam_addr_ndma), 32'd0);
    tick_to(ticks + 165, 4);

    // Write and tick on the same clock from IDLE.
    cyc(1'b1, 1'b1, 8'h90);
    tick_to(ticks + 165, 2);

    // Reset at idx 0x50, then a clean transfer.
    cyc(1'b0, 1'b1, 8'hC3);
    p = ticks;
    tick_to(p + 2 + 8'h50, 4);
    @(posedge clk);
    #1;
    bus.mcyc_en = 1'b0;
    nreset      = 1'b0;
    sb.delete();
    have_cur = 1'b0;
    exp_regq = 8'h00;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(negedge clk);
    check("midrst_dma_run", 32'(bus.dma_run), 32'd0);
    check("midrst_dma_a", 32'(bus.dma_a), 32'h0000);
    check("midrst_reg_q", 32'(bus.reg_q), 32'h00);
    cyc(1'b0, 1'b1, 8'hC2);
    tick_to(ticks + 165, 3);

    // Freeze for 100 clocks mid-RUN.
    cyc(1'b0, 1'b1, 8'h81);
    p = ticks;
    tick_to(p + 42, 2);
    cyc(1'b0);
    @(negedge clk);
    check("freeze_dma_a_before", 32'(bus.dma_a), 32'h8128);
    repeat (100) cyc(1'b0);
    @(negedge clk);
    check("freeze_dma_a_after", 32'(bus.dma_a), 32'h8128);
    tick_to(p + 170, 2);

    // Randomized writes at random distances, including the 160/161 boundaries.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       d = 8'hE0 | 8'($urandom_range(0, 31));
        1:       d = 8'h80 | 8'($urandom_range(0, 31));
        default: d = 8'($urandom);
      endcase
      per = $urandom_range(1, 3);
      case ($urandom_range(0, 4))
        0:       gap = $urandom_range(158, 163);
        1:       gap = $urandom_range(0, 3);
        default: gap = $urandom_range(0, 120);
      endcase
      cyc(1'($urandom_range(0, 1)), 1'b1, d);
      if ($urandom_range(0, 7) == 0) repeat (100) cyc(1'b0);
      tick_to(ticks + gap, per);
    end
    tick_to(ticks + 170, 1);
    cyc(1'b0);
    cyc(1'b0);
    if (have_cur) exp_done++;
    @(negedge clk);
    check("final_queue_empty", 32'(sb.size()), 32'd0);
    check("final_done_count", 32'(done_seen), 32'(exp_done));
    check("final_reg_q", 32'(bus.reg_q), 32'(exp_regq));
    check("final_dma_run", 32'(bus.dma_run), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
